// File: rtl/hazard_pkg.sv
// Shared types and encodings for the hazard control unit: FSM states,
// operand-forwarding select codes and the hard-wired zero register index.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_LOAD_STALL = 2'b01,
        ST_DIV_BUSY   = 2'b10
    } hazard_state_t;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam int REG_ZERO = 0;

    // The younger producer (EX) always carries the newer value, so it wins.
    function automatic logic [1:0] fwd_pick(input logic used,
                                            input logic ex_hit,
                                            input logic mem_hit);
        logic [1:0] sel;
        sel = FWD_RF;
        if (used && ex_hit)
            sel = FWD_EXMEM;
        else if (used && mem_hit)
            sel = FWD_MEMWB;
        return sel;
    endfunction

endpackage

// File: rtl/hazard_control_unit_stall_down_counter.sv
// Shared stall down-counter: load has priority over clear, decrement
// saturates at zero, zero flag is combinational from the count.
module stall_down_counter
    import hazard_pkg::*;
#(
    parameter int CNT_W = 1
)(
    input  logic             CLK,
    input  logic             RESET,
    input  logic             load,
    input  logic             clear,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (clear)
            count <= '0;
        else if (dec && (count != '0))
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: load-use stall, optional multi-cycle DIV stall
// (HAZARD_DIV_STALL_EN) and registered EX operand-forwarding selects.
//
// state         | meaning
// ST_IDLE       | no stall pending; load-use stall driven combinationally
// ST_LOAD_STALL | extra load-use bubble cycles, abortable by branch_flush
// ST_DIV_BUSY   | DIV/REM occupying EX, not abortable
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W     = 5,
    parameter int LOAD_STALL_CYC = 1,
    parameter int DIV_CYCLES     = 32
)(
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic [REG_ADDR_W-1:0] mem_rd_addr,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic                  mem_reg_write,
    input  logic                  ex_div_start,
    input  logic                  branch_flush,
    output logic                  stall_if_id,
    output logic                  bubble_id_ex,
    output logic [1:0]            fwd_sel_rs1,
    output logic [1:0]            fwd_sel_rs2,
    output logic                  busy
);

`ifdef HAZARD_DIV_STALL_EN
    localparam int CNT_MAX = (DIV_CYCLES - 2 > LOAD_STALL_CYC - 1) ?
                             DIV_CYCLES - 2 : LOAD_STALL_CYC - 1;
`else
    localparam int CNT_MAX = LOAD_STALL_CYC - 1;
`endif
    localparam int CNT_W = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    // The detection cycle in IDLE is already the first bubble, so LOAD_STALL
    // runs LOAD_STALL_CYC-1 more cycles, ending after the count-0 cycle.
    localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LOAD_STALL_CYC - 2);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES - 2);
    localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = REG_ADDR_W'(REG_ZERO);

    hazard_state_t    state, state_nxt;
    logic             div_req;
    logic             load_use;
    logic             stall_raw;
    logic             cnt_load, cnt_clear, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_load_val;
    logic             rs1_ex_hit, rs2_ex_hit, rs1_mem_hit, rs2_mem_hit;

`ifdef HAZARD_DIV_STALL_EN
    assign div_req = ex_div_start;
`else
    logic div_start_unused;
    assign div_start_unused = ex_div_start;
    assign div_req          = 1'b0;
`endif

    assign rs1_ex_hit  = ex_reg_write  && (ex_rd_addr  != ZERO_ADDR) && (id_rs1_addr == ex_rd_addr);
    assign rs2_ex_hit  = ex_reg_write  && (ex_rd_addr  != ZERO_ADDR) && (id_rs2_addr == ex_rd_addr);
    assign rs1_mem_hit = mem_reg_write && (mem_rd_addr != ZERO_ADDR) && (id_rs1_addr == mem_rd_addr);
    assign rs2_mem_hit = mem_reg_write && (mem_rd_addr != ZERO_ADDR) && (id_rs2_addr == mem_rd_addr);

    assign load_use = ex_mem_read && ((id_rs1_used && rs1_ex_hit) || (id_rs2_used && rs2_ex_hit));

    stall_down_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .CLK      (CLK),
        .RESET    (RESET),
        .load     (cnt_load),
        .clear    (cnt_clear),
        .dec      (cnt_dec),
        .load_val (cnt_load_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        stall_raw    = 1'b0;
        cnt_load     = 1'b0;
        cnt_clear    = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = '0;
        case (state)
            ST_IDLE: begin
                // A load cannot sit in EX alongside a DIV, so DIV goes first.
                if (div_req) begin
                    state_nxt    = ST_DIV_BUSY;
                    cnt_load     = 1'b1;
                    cnt_load_val = DIV_CNT;
                end else if (load_use) begin
                    stall_raw = 1'b1;
                    if (LOAD_STALL_CYC > 1) begin
                        state_nxt    = ST_LOAD_STALL;
                        cnt_load     = 1'b1;
                        cnt_load_val = LOAD_CNT;
                    end
                end
            end
            ST_LOAD_STALL: begin
                stall_raw = 1'b1;
                if (branch_flush) begin
                    state_nxt = ST_IDLE;
                    cnt_clear = 1'b1;
                end else if (cnt_zero)
                    state_nxt = ST_IDLE;
                else
                    cnt_dec = 1'b1;
            end
            ST_DIV_BUSY: begin
                stall_raw = 1'b1;
                if (cnt_zero)
                    state_nxt = ST_IDLE;
                else
                    cnt_dec = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Reset gating keeps the combinational IDLE stall quiet while in reset.
    assign stall_if_id  = stall_raw & RESET;
    assign bubble_id_ex = stall_raw & RESET;
    assign busy         = (state != ST_IDLE);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            fwd_sel_rs1 <= FWD_RF;
            fwd_sel_rs2 <= FWD_RF;
        end else if (stall_raw) begin
            fwd_sel_rs1 <= FWD_RF;
            fwd_sel_rs2 <= FWD_RF;
        end else begin
            fwd_sel_rs1 <= fwd_pick(id_rs1_used, rs1_ex_hit, rs1_mem_hit);
            fwd_sel_rs2 <= fwd_pick(id_rs2_used, rs2_ex_hit, rs2_mem_hit);
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: one instance with a single load
// bubble and one with three, driven by the same pipeline stimulus.
module tb_hazard_control_unit;

`ifdef HAZARD_DIV_STALL_EN
    localparam int DIV_STALL_EXP = 31;
`else
    localparam int DIV_STALL_EXP = 0;
`endif

    logic       CLK = 1'b0;
    logic       RESET;
    logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr, mem_rd_addr;
    logic       id_rs1_used, id_rs2_used;
    logic       ex_reg_write, ex_mem_read, mem_reg_write, ex_div_start, branch_flush;

    logic       stall1, bubble1, busy1;
    logic [1:0] f1_rs1, f1_rs2;
    logic       stall3, bubble3, busy3;
    logic [1:0] f3_rs1, f3_rs2;

    int n_vec = 0;
    int n_err = 0;
    int cnt;

    always #5 CLK = ~CLK;

    hazard_control_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYC(1), .DIV_CYCLES(32)) u_dut1 (
        .CLK(CLK), .RESET(RESET),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd_addr(ex_rd_addr), .mem_rd_addr(mem_rd_addr),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_reg_write(mem_reg_write), .ex_div_start(ex_div_start),
        .branch_flush(branch_flush),
        .stall_if_id(stall1), .bubble_id_ex(bubble1),
        .fwd_sel_rs1(f1_rs1), .fwd_sel_rs2(f1_rs2), .busy(busy1)
    );

    hazard_control_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYC(3), .DIV_CYCLES(32)) u_dut3 (
        .CLK(CLK), .RESET(RESET),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd_addr(ex_rd_addr), .mem_rd_addr(mem_rd_addr),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_reg_write(mem_reg_write), .ex_div_start(ex_div_start),
        .branch_flush(branch_flush),
        .stall_if_id(stall3), .bubble_id_ex(bubble3),
        .fwd_sel_rs1(f3_rs1), .fwd_sel_rs2(f3_rs2), .busy(busy3)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1_addr   = '0; id_rs2_addr = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_rd_addr    = '0; mem_rd_addr = '0;
        ex_reg_write  = 1'b0; ex_mem_read = 1'b0; mem_reg_write = 1'b0;
        ex_div_start  = 1'b0; branch_flush = 1'b0;
    endtask

    // lw x5 in EX, ID reads x5 on rs1 and x7 on rs2
    task automatic drive_load_use();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd_addr = 5'd5;
        id_rs1_addr = 5'd5; id_rs1_used = 1'b1;
        id_rs2_addr = 5'd7; id_rs2_used = 1'b1;
    endtask

    initial begin
        RESET = 1'b0;
        idle_inputs();
        drive_load_use();
        #12;
        check_val("rst_stall_gated", stall1, 0);
        check_val("rst_bubble_gated", bubble3, 0);
        check_val("rst_busy", busy3, 0);
        check_val("rst_fwd_rs1", f1_rs1, 0);
        check_val("rst_fwd_rs2", f3_rs2, 0);
        idle_inputs();
        @(negedge CLK);
        RESET = 1'b1;
        tick();

        // load-use: 1 bubble on dut1, 3 on dut3, then MEM/WB forwarding
        drive_load_use();
        #1;
        check_val("lu_c0_stall1", stall1, 1);
        check_val("lu_c0_bubble1", bubble1, 1);
        check_val("lu_c0_busy1", busy1, 0);
        check_val("lu_c0_stall3", stall3, 1);
        check_val("lu_c0_busy3", busy3, 0);
        tick();
        ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_rd_addr = '0;
        mem_rd_addr = 5'd5; mem_reg_write = 1'b1;
        #1;
        check_val("lu_c1_stall1", stall1, 0);
        check_val("lu_c1_fwd1_stalled", f1_rs1, 0);
        check_val("lu_c1_stall3", stall3, 1);
        check_val("lu_c1_busy3", busy3, 1);
        tick();
        check_val("lu_c2_fwd1_rs1", f1_rs1, 2);
        check_val("lu_c2_fwd1_rs2", f1_rs2, 0);
        check_val("lu_c2_stall3", stall3, 1);
        check_val("lu_c2_busy3", busy3, 1);
        check_val("lu_c2_fwd3_rs1", f3_rs1, 0);
        tick();
        check_val("lu_c3_stall3", stall3, 0);
        check_val("lu_c3_busy3", busy3, 0);
        check_val("lu_c3_fwd3_rs1", f3_rs1, 0);
        tick();
        check_val("lu_c4_fwd3_rs1", f3_rs1, 2);
        idle_inputs();
        tick();

        // forwarding priority and x0
        ex_rd_addr = 5'd9; mem_rd_addr = 5'd9; ex_reg_write = 1'b1; mem_reg_write = 1'b1;
        id_rs1_addr = 5'd3; id_rs1_used = 1'b1; id_rs2_addr = 5'd9; id_rs2_used = 1'b1;
        #1;
        check_val("fw_both_stall", stall1, 0);
        tick();
        check_val("fw_both_rs2", f1_rs2, 1);
        check_val("fw_both_rs1", f1_rs1, 0);
        id_rs2_used = 1'b0;
        tick();
        check_val("fw_unused_rs2", f1_rs2, 0);
        id_rs2_used = 1'b1; ex_reg_write = 1'b0;
        tick();
        check_val("fw_mem_only_rs2", f1_rs2, 2);
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd_addr = '0;
        mem_rd_addr = '0; mem_reg_write = 1'b1;
        id_rs1_addr = '0; id_rs2_addr = '0;
        #1;
        check_val("x0_no_stall", stall1, 0);
        check_val("x0_no_stall3", stall3, 0);
        tick();
        check_val("x0_fwd_rs1", f1_rs1, 0);
        check_val("x0_fwd_rs2", f1_rs2, 0);
        idle_inputs();
        tick();

        // branch flush during the 2nd stall cycle of dut3
        drive_load_use();
        tick();
        idle_inputs();
        branch_flush = 1'b1;
        #1;
        check_val("fl_stall_in_flush", stall3, 1);
        tick();
        branch_flush = 1'b0;
        #1;
        check_val("fl_stall_after", stall3, 0);
        check_val("fl_busy_after", busy3, 0);
        tick();

        // DIV occupancy
        ex_div_start = 1'b1;
        #1;
        check_val("div_start_stall", stall1, 0);
        tick();
        ex_div_start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (stall1) cnt++;
            tick();
        end
        check_val("div_stall_cycles", cnt, DIV_STALL_EXP);
        check_val("div_done_busy", busy1, 0);

        // reset in the middle of a DIV
        ex_div_start = 1'b1;
        tick();
        ex_div_start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check_val("rd_busy_before", busy1, (DIV_STALL_EXP > 0) ? 1 : 0);
        #3;
        RESET = 1'b0;
        #1;
        check_val("rd_async_stall", stall1, 0);
        check_val("rd_async_bubble", bubble1, 0);
        check_val("rd_async_busy", busy1, 0);
        @(negedge CLK);
        RESET = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (stall1 || busy1) cnt++;
        end
        check_val("rd_no_residual", cnt, 0);

        // asynchronous clear of a live forwarding select
        ex_rd_addr = 5'd4; ex_reg_write = 1'b1; id_rs1_addr = 5'd4; id_rs1_used = 1'b1;
        tick();
        check_val("ra_fwd_before", f1_rs1, 1);
        #3;
        RESET = 1'b0;
        #1;
        check_val("ra_fwd_async", f1_rs1, 0);
        idle_inputs();
        @(negedge CLK);
        RESET = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
